// File: rtl/match_sched_ctrl.sv
// Address sequencer for the 4-wide descriptor-distance compare datapath.
// Walks image groups (outer) and targets (inner) and retires min/min2 updates to the match memory.
module match_sched_ctrl #(
   parameter int TAR_AW = 10,
   parameter int GRP_AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TAR_AW:0]   num_tar,
   input  logic [GRP_AW:0]   num_grp,
   input  logic              cmp_we,
   output logic [TAR_AW-1:0] tar_addr,
   output logic [GRP_AW-1:0] img_addr,
   output logic [TAR_AW-1:0] mtc_raddr,
   output logic [TAR_AW-1:0] mtc_waddr,
   output logic              mtc_we,
   output logic              first_img_grp,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   localparam logic [TAR_AW:0] ONE_TAR = {{TAR_AW{1'b0}}, 1'b1};
   localparam logic [GRP_AW:0] ONE_GRP = {{GRP_AW{1'b0}}, 1'b1};

   state_t            state;
   logic [TAR_AW:0]   num_tar_q;
   logic [GRP_AW:0]   num_grp_q;
   logic [TAR_AW-1:0] t;
   logic [GRP_AW-1:0] g;
   logic              bubble;
   logic              s1_valid;
   logic              s1_first;
   logic [TAR_AW-1:0] s1_t;

   logic              s0_valid;
   logic              tar_wrap;
   logic              grp_last;

   assign s0_valid = (state == RUN) && !bubble;
   assign tar_wrap = ({1'b0, t} == num_tar_q - ONE_TAR);
   assign grp_last = ({1'b0, g} == num_grp_q - ONE_GRP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         num_tar_q <= '0;
         num_grp_q <= '0;
         t         <= '0;
         g         <= '0;
         bubble    <= 1'b0;
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_t      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments everywhere here so every branch sees the pre-edge state.
         done     <= 1'b0;
         s1_valid <= s0_valid;
         s1_t     <= t;
         s1_first <= (g == '0);
         case (state)
            IDLE: begin
               if (start) begin
                  num_tar_q <= num_tar;
                  num_grp_q <= num_grp;
                  t         <= '0;
                  g         <= '0;
                  bubble    <= 1'b0;
                  busy      <= 1'b1;
                  state     <= (num_tar != '0 && num_grp != '0) ? RUN : FIN;
               end
            end
            RUN: begin
               if (bubble) begin
                  bubble <= 1'b0;
               end else if (tar_wrap) begin
                  t <= '0;
                  if (grp_last) begin
                     g     <= '0;
                     state <= DRAIN;
                  end else begin
                     g      <= g + 1'b1;
                     // A lone target would be re-read while its write is still in S1.
                     bubble <= (num_tar_q == ONE_TAR);
                  end
               end else begin
                  t <= t + 1'b1;
               end
            end
            DRAIN: state <= FIN;
            FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tar_addr      = t;
   assign mtc_raddr     = t;
   assign img_addr      = g;
   assign mtc_waddr     = s1_t;
   assign first_img_grp = s1_valid & s1_first;
   // The first group always writes so stale match entries are overwritten.
   assign mtc_we        = s1_valid & (s1_first | cmp_we);

endmodule

// File: tb/tb_match_sched_ctrl.sv
// Self-checking bench for match_sched_ctrl: per-job schedule model built from the
// loop order, bubble rule and fixed start/drain/finish overhead.
module tb_match_sched_ctrl;

   localparam int TAR_AW = 10;
   localparam int GRP_AW = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [TAR_AW:0]   num_tar;
   logic [GRP_AW:0]   num_grp;
   logic              cmp_we;
   logic [TAR_AW-1:0] tar_addr;
   logic [GRP_AW-1:0] img_addr;
   logic [TAR_AW-1:0] mtc_raddr;
   logic [TAR_AW-1:0] mtc_waddr;
   logic              mtc_we;
   logic              first_img_grp;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   match_sched_ctrl #(.TAR_AW(TAR_AW), .GRP_AW(GRP_AW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_tar(num_tar), .num_grp(num_grp),
      .cmp_we(cmp_we), .tar_addr(tar_addr), .img_addr(img_addr), .mtc_raddr(mtc_raddr),
      .mtc_waddr(mtc_waddr), .mtc_we(mtc_we), .first_img_grp(first_img_grp),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // we_mode: 0 = cmp_we low, 1 = cmp_we high, 2 = random. restart_cyc: cycle of a stray start (-1 none).
   task automatic run_job(input string name, input int nt, input int ng, input int we_mode,
                          input int restart_cyc);
      int   q_t[$];
      int   q_g[$];
      bit   q_v[$];
      int   len, done_cyc, writes;
      bit   s0v, s1v, exp_busy, exp_done, exp_we, exp_first;
      int   s0t, s0g, s1t, s1g;
      for (int gi = 0; gi < ng; gi++) begin
         for (int ti = 0; ti < nt; ti++) begin
            q_v.push_back(1'b1); q_t.push_back(ti); q_g.push_back(gi);
         end
         if (nt == 1 && gi < ng - 1) begin
            q_v.push_back(1'b0); q_t.push_back(0); q_g.push_back(0);
         end
      end
      len      = q_v.size();
      done_cyc = (nt == 0 || ng == 0) ? 2 : len + 3;
      writes   = 0;
      for (int c = 0; c <= done_cyc + 1; c++) begin
         @(negedge clk);
         start = (c == 0) || (c == restart_cyc);
         if (c == 0) begin
            num_tar = (TAR_AW + 1)'(nt);
            num_grp = (GRP_AW + 1)'(ng);
         end else begin
            num_tar = (TAR_AW + 1)'($urandom_range(2, 9));
            num_grp = (GRP_AW + 1)'($urandom_range(2, 9));
         end
         case (we_mode)
            0:       cmp_we = 1'b0;
            1:       cmp_we = 1'b1;
            default: cmp_we = 1'($urandom_range(0, 1));
         endcase
         #1;
         exp_busy = (c >= 1 && c < done_cyc);
         exp_done = (c == done_cyc);
         s0v = 1'b0; s0t = 0; s0g = 0;
         if (c >= 1 && c <= len) begin
            s0v = q_v[c-1]; s0t = q_t[c-1]; s0g = q_g[c-1];
         end
         s1v = 1'b0; s1t = 0; s1g = 0;
         if (c >= 2 && c <= len + 1) begin
            s1v = q_v[c-2]; s1t = q_t[c-2]; s1g = q_g[c-2];
         end
         exp_first = s1v && (s1g == 0);
         exp_we    = s1v && (exp_first || cmp_we);
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, busy, exp_busy);
         end
         checks++;
         if (done !== exp_done) begin
            errors++;
            $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, exp_done);
         end
         checks++;
         if (mtc_we !== exp_we || first_img_grp !== exp_first) begin
            errors++;
            $display("FAIL %s we/first c=%0d got=%b/%b exp=%b/%b", name, c, mtc_we,
                     first_img_grp, exp_we, exp_first);
         end
         if (exp_we) begin
            writes++;
            checks++;
            if (mtc_waddr !== TAR_AW'(s1t)) begin
               errors++;
               $display("FAIL %s waddr c=%0d got=%0d exp=%0d", name, c, mtc_waddr, s1t);
            end
         end
         if (s0v) begin
            checks++;
            if (tar_addr !== TAR_AW'(s0t) || mtc_raddr !== TAR_AW'(s0t) ||
                img_addr !== GRP_AW'(s0g)) begin
               errors++;
               $display("FAIL %s issue c=%0d got t=%0d r=%0d g=%0d exp t=%0d g=%0d", name, c,
                        tar_addr, mtc_raddr, img_addr, s0t, s0g);
            end
            if (mtc_we === 1'b1) begin
               checks++;
               if (mtc_waddr === mtc_raddr) begin
                  errors++;
                  $display("FAIL %s hazard c=%0d addr got=%0d exp=different", name, c, mtc_raddr);
               end
            end
         end
      end
      start = 1'b0;
      if (nt == 0 || ng == 0 || we_mode == 0) begin
         checks++;
         if (writes != ((nt == 0 || ng == 0) ? 0 : nt)) begin
            errors++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, writes, nt);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; cmp_we = 1'b1; num_tar = '0; num_grp = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mtc_we !== 1'b0 || first_img_grp !== 1'b0 ||
          tar_addr !== '0 || img_addr !== '0 || mtc_raddr !== '0 || mtc_waddr !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b we=%b first=%b t=%0d g=%0d w=%0d exp all 0",
                  busy, done, mtc_we, first_img_grp, tar_addr, img_addr, mtc_waddr);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int dones = 0;
      @(negedge clk);
      start = 1'b1; num_tar = 11'd4; num_grp = 11'd3; cmp_we = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mtc_we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got we=%b busy=%b exp we=0 busy=0", mtc_we, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1 || mtc_we === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL mid_reset_quiet got=%0d done/we cycles exp=0", dones);
      end
      run_job("after_reset", 4, 3, 2, -1);
   endtask

   task automatic test_basic();
      run_job("basic_3x2", 3, 2, 0, -1);
   endtask

   task automatic test_single_target();
      run_job("single_tar", 1, 3, 1, -1);
   endtask

   task automatic test_zero_counts();
      run_job("zero_tar", 0, 3, 1, -1);
      run_job("zero_grp", 4, 0, 1, -1);
   endtask

   task automatic test_restart_ignored();
      run_job("restart_early", 3, 2, 0, 3);
      run_job("restart_fin", 2, 2, 1, 6);
   endtask

   task automatic test_random_cmp();
      run_job("rand_5x4", 5, 4, 2, -1);
      for (int i = 0; i < 6; i++)
         run_job("rand_job", $urandom_range(1, 6), $urandom_range(1, 4), 2, -1);
   endtask

   task automatic test_back_to_back();
      run_job("b2b_a", 2, 3, 2, -1);
      run_job("b2b_b", 1, 2, 2, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single_target();
      test_zero_counts();
      test_restart_ignored();
      test_random_cmp();
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_sched_ctrl.md
Name: match_sched_ctrl

Overview:
- Sequencer for the 4-wide descriptor-distance compare datapath (target vs. four image descriptors, running min/min2 per target in the match memory).
- Loops outer over image groups (4 descriptors per group) and inner over targets.
- For each step it drives the target, image-group and match-memory read addresses, the first-group flag, and the match-memory write strobe and write address.
- Sits between the top-level matching FSM (start/done) and the synchronous-read descriptor/match SRAMs.

Parameters:
- TAR_AW, 10, target/match-memory address width (max 2^TAR_AW targets)
- GRP_AW, 10, image-group memory address width (max 2^GRP_AW groups)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; accepted only in IDLE
- num_tar  in  TAR_AW+1  target count, sampled at accepted start
- num_grp  in  GRP_AW+1  image-group count, sampled at accepted start
- cmp_we  in  1  write-request output of the compare datapath (min or min2 improved)
- tar_addr  out  TAR_AW  target descriptor memory read address
- img_addr  out  GRP_AW  image-group memory read address
- mtc_raddr  out  TAR_AW  match memory read address (equals tar_addr)
- mtc_waddr  out  TAR_AW  match memory write address
- mtc_we  out  1  match memory write enable
- first_img_grp  out  1  first-group flag to datapath, aligned with returned read data
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse when the last write has retired

Behaviour:
- Reset: state=IDLE; all addresses 0; mtc_we, first_img_grp, busy and done all 0. Reset mid-run aborts immediately: no further writes and no done pulse.
- Memories have 1-cycle read latency. Stage S0 issues tar_addr/img_addr/mtc_raddr. Stage S1 (next cycle) holds the data at the datapath. s1_valid, s1_t and s1_first are registered copies of the S0 values.
- Outputs in S1:
  - first_img_grp = s1_valid & s1_first
  - mtc_waddr = s1_t
  - mtc_we = s1_valid & (s1_first | cmp_we). The first group always writes so that stale memory contents are overwritten.
- FSM states:
  - IDLE: on start, go to RUN if num_tar≠0 and num_grp≠0; otherwise go to FIN. Counters t=0, g=0. busy rises the cycle after start.
  - RUN: each cycle issues (t,g) with s0_valid=1.
    - If t==num_tar-1: t←0, g←g+1. If g==num_grp-1, go to DRAIN.
    - Otherwise t←t+1.
    - Hazard rule: when num_tar==1, the next group would read the address being written in S1. Insert one bubble cycle (s0_valid=0) between groups, so a read never coincides with an in-flight write to the same address.
  - DRAIN: one cycle; retires the last S1 write. Then go to FIN.
  - FIN: done=1 for one cycle, busy falls, go to IDLE.
- Cycle count:
  - From start to done: num_tar·num_grp + 3 cycles (start→RUN 1, DRAIN 1, FIN 1).
  - When num_tar==1, add num_grp−1 bubble cycles.
  - Zero counts: done occurs 2 cycles after start and no write is issued.
- start while busy is ignored. num_tar and num_grp changes after start are ignored.
- cmp_we is only meaningful while s1_valid. It is ignored during bubbles, in DRAIN's idle S0 and in IDLE.
- Counters are num_tar/num_grp-bounded, so no wrap occurs. Full-size counts (2^TAR_AW, 2^GRP_AW) are legal.

Test Plan:
- Reset mid-RUN at cycle 5 of a num_tar=4/num_grp=3 job → mtc_we=0 on the next cycle; busy=0; no done; a new start afterwards runs normally.
- num_tar=3, num_grp=2, cmp_we held 0 → issue order (t,g)=(0,0),(1,0),(2,0),(0,1),(1,1),(2,1). Writes occur only for g=0 (waddr 0,1,2) with first_img_grp=1. done arrives at cycle 9 after start.
- num_tar=1, num_grp=3, cmp_we=1 → a bubble occurs between each group; 3 writes to addr 0; a read of addr 0 never shares a cycle with mtc_we=1 for addr 0; done arrives at cycle 8 after start.
- num_tar=0 or num_grp=0 → busy high for 1 cycle, done 2 cycles after start, no mtc_we.
- start pulsed again while busy, with different counts → ignored; the original sequence and done timing are unchanged.
- Random cmp_we on num_tar=5, num_grp=4 → mtc_we equals (g==0)|cmp_we exactly in S1, with mtc_waddr equal to the target issued one cycle earlier (checked against a scoreboard).
